jtdsp16_ram: RTL
================

Name: jtdsp16_ram

Overview:
- Data RAM responder for the DSP16 core. It serves the addresses generated by the RAM address arithmetic unit and drives the `ram_dout` word that unit loads from.
- Holds the 2K×16 data RAM, built as a single-port synchronous array.
- Core writes are posted through a one-entry write buffer, and core reads see that buffer through read-after-write forwarding.
- A low-priority host/debug port gets the array in cycles the core does not need it, using a req/ack handshake.

Parameters:
- AW, 11, address width of the physical array (2^AW words).
- DW, 16, data word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, sampled on the rising edge of clk.
- cen  in  1  core clock enable; core port inputs are sampled only when cen=1.
- ram_addr  in  16  core address from the address unit.
- ram_rd  in  1  core read request (qualified by cen).
- ram_wr  in  1  core write request (qualified by cen); ram_rd and ram_wr are never both 1.
- ram_din  in  DW  core write data.
- ram_dout  out  DW  core read data; registered, held between reads.
- host_req  in  1  host access request, level.
- host_we  in  1  host write (1) or read (0); held stable while host_req=1.
- host_addr  in  AW  host address; held stable while host_req=1.
- host_din  in  DW  host write data; held stable while host_req=1.
- host_ack  out  1  one-clk pulse marking host access complete.
- host_dout  out  DW  host read data; valid while host_ack=1, held afterwards.
- oor_err  out  1  sticky flag: a core access hit an address at or above 2^AW.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - ram_dout=0, host_dout=0, host_ack=0, oor_err=0.
  - Write buffer valid bit cleared; a pending write is discarded.
  - Host FSM returns to IDLE.
  - Array contents are not reset.
- Array port: one operation per clk. Priority is:
  1. core read (cen & ram_rd & in-range)
  2. write-buffer drain
  3. host access
- Core read:
  - Issued at clk edge t with cen=1; ram_dout updates at edge t+1 and holds until the next core read completes.
  - If the write buffer is valid and its address equals ram_addr[AW-1:0], ram_dout takes the buffered data (forwarding) instead of the array data.
- Core write (cen & ram_wr):
  - Captured into the buffer as {addr, data, valid=1}.
  - If the buffer was already valid, the old entry drains to the array in the same clk. This is legal because a write cycle carries no core read.
  - Because of this, the buffer never overflows and its depth stays 1.
- Drain: in any clk with no core read and the buffer valid (and no new write in the same clk), write the entry to the array and clear valid. Draining proceeds regardless of cen.
- Out-of-range (ram_addr[15:AW] != 0, with cen=1 and an access):
  - A read loads ram_dout=0.
  - A write is dropped and not buffered.
  - oor_err is set and stays set until rst.
- Host FSM:
  - IDLE: if host_req=1 and the port is free this clk (no core read, no drain), perform the access and go to ACK. A host read forwards from a buffer entry if the buffer is valid. A core write enqueued in that same clk is ordered after the host write.
  - ACK: host_ack=1 for one clk; host_dout holds the read data (unchanged on a write); then return to IDLE.
  - The host must drop host_req in the ACK clk. If host_req is still 1 in IDLE, a new access starts.
  - The host may wait indefinitely under continuous core reads; there is no fairness guarantee.
- Reset during ACK: the ack is suppressed. Reset during a host access cycle: a host write may or may not be in the array.

Decomposition:
- Shared header jtdsp16_ram_defs (or a localparam block): default AW/DW, host FSM state encodings (IDLE, ACK), and the port-priority encoding.
- One natural sub-module, jtdsp16_ram_array: single-port synchronous RAM with parameters AW and DW, ports clk, we, addr, din, dout, and no reset.
- Arbitration, write buffer, forwarding and the host FSM stay in jtdsp16_ram.

Test Plan:
- Reset: hold rst 2 clks with the buffer valid and the FSM in ACK -> ram_dout=0, host_ack=0, oor_err=0, buffer discarded (a read of that address returns the old array value).
- Write then read: cen every clk, write 0x0123 <- 0xBEEF, next clk read 0x0123 -> ram_dout=0xBEEF one clk after the read (forwarded); read again 5 clks later -> 0xBEEF from the array.
- Back-to-back writes: W 0x10=0x1111, W 0x11=0x2222, W 0x10=0x3333, then reads -> 0x10=0x3333, 0x11=0x2222; the buffer never holds more than one entry.
- Out-of-range: read 0x0800 with AW=11 -> ram_dout=0 and oor_err=1 until rst; write 0xF800=0xAAAA -> no array location changes.
- Host arbitration: host write 0x020=0x5A5A during continuous core reads -> no host_ack; when reads stop, host_ack pulses exactly once; a core read of 0x020 then returns 0x5A5A.
- Host read with a pending write: core writes 0x030=0x7777, host reads 0x030 in the same window -> host_dout=0x7777 on host_ack.

Source files
------------

// File: rtl/jtdsp16_ram_pkg.sv
// Shared definitions for the DSP16 data RAM responder: default geometry,
// host handshake states and the array-port owner encoding.
package jtdsp16_ram_pkg;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 16;

    // Host handshake FSM
    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_ACK  = 1'b1
    } host_st_t;

    // Owner of the single array port in a given clk, highest priority first
    typedef enum logic [1:0] {
        PORT_NONE    = 2'd0,
        PORT_CORE_RD = 2'd1,
        PORT_DRAIN   = 2'd2,
        PORT_HOST    = 2'd3
    } port_sel_t;

endpackage

// File: rtl/jtdsp16_ram_array.sv
// Single-port synchronous RAM, read-first, registered output, no reset.
module jtdsp16_ram_array
    import jtdsp16_ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // One access per clk: optional write, and the old word at addr is registered
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/jtdsp16_ram.sv
// DSP16 data RAM responder: arbitrates the single-port array between core
// reads, a one-entry posted write buffer and a low-priority host port.
module jtdsp16_ram
    import jtdsp16_ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [15:0]   ram_addr,
    input  logic          ram_rd,
    input  logic          ram_wr,
    input  logic [DW-1:0] ram_din,
    output logic [DW-1:0] ram_dout,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic          host_ack,
    output logic [DW-1:0] host_dout,
    output logic          oor_err
);

    logic          in_range;
    logic          core_rd;
    logic          core_wr;
    logic          oor_rd;
    logic          oor_acc;
    logic          fwd_hit;
    port_sel_t     port_sel;

    logic          arr_we;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_din;
    logic [DW-1:0] arr_dout;

    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;

    logic          rd_pend;
    logic          rd_oor;
    logic          rd_fwd;
    logic [DW-1:0] rd_fwd_data;

    host_st_t      host_st;
    logic          host_rd_q;
    logic [DW-1:0] host_dout_q;

    // Request decode and array-port arbitration
    always_comb begin
        in_range = (ram_addr[15:AW] == '0);
        core_rd  = cen & ram_rd & in_range;
        core_wr  = cen & ram_wr & in_range;
        oor_rd   = cen & ram_rd & ~in_range;
        oor_acc  = cen & (ram_rd | ram_wr) & ~in_range;
        fwd_hit  = core_rd & buf_valid & (buf_addr == ram_addr[AW-1:0]);

        // A valid entry drains whenever no core read holds the port; a new
        // write in the same clk simply replaces it in the buffer afterwards.
        // The host is therefore only granted with the buffer empty, so host
        // reads never need forwarding.
        port_sel = PORT_NONE;
        if (core_rd)
            port_sel = PORT_CORE_RD;
        else if (buf_valid)
            port_sel = PORT_DRAIN;
        else if (host_st == HOST_IDLE && host_req)
            port_sel = PORT_HOST;

        arr_we   = 1'b0;
        arr_addr = ram_addr[AW-1:0];
        arr_din  = buf_data;
        case (port_sel)
            PORT_DRAIN: begin
                arr_we   = ~rst;
                arr_addr = buf_addr;
                arr_din  = buf_data;
            end
            PORT_HOST: begin
                arr_we   = host_we & ~rst;
                arr_addr = host_addr;
                arr_din  = host_din;
            end
            default: ;
        endcase
    end

    jtdsp16_ram_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .din  (arr_din),
        .dout (arr_dout)
    );

    // Posted write buffer: capture core writes, clear on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (core_wr) begin
            buf_valid <= 1'b1;
            buf_addr  <= ram_addr[AW-1:0];
            buf_data  <= ram_din;
        end else if (port_sel == PORT_DRAIN) begin
            buf_valid <= 1'b0;
        end
    end

    // Core read pipeline: note source at issue, load ram_dout one clk later
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_oor   <= 1'b0;
            rd_fwd   <= 1'b0;
            ram_dout <= '0;
        end else begin
            rd_pend <= core_rd | oor_rd;
            rd_oor  <= oor_rd;
            rd_fwd  <= fwd_hit;
            if (fwd_hit) rd_fwd_data <= buf_data;
            if (rd_pend) ram_dout <= rd_oor ? '0 : (rd_fwd ? rd_fwd_data : arr_dout);
        end
    end

    // Sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (rst)          oor_err <= 1'b0;
        else if (oor_acc) oor_err <= 1'b1;
    end

    // Host handshake FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            host_st     <= HOST_IDLE;
            host_rd_q   <= 1'b0;
            host_dout_q <= '0;
        end else begin
            case (host_st)
                HOST_IDLE: begin
                    if (port_sel == PORT_HOST) begin
                        host_st   <= HOST_ACK;
                        host_rd_q <= ~host_we;
                    end
                end
                HOST_ACK: begin
                    host_st   <= HOST_IDLE;
                    host_rd_q <= 1'b0;
                    if (host_rd_q) host_dout_q <= arr_dout;
                end
                default: host_st <= HOST_IDLE;
            endcase
        end
    end

    // Array data arrives during the ACK clk; it is shown directly then and held after
    always_comb begin
        host_ack  = (host_st == HOST_ACK);
        host_dout = host_rd_q ? arr_dout : host_dout_q;
    end

endmodule
